uart_tx_serialiser: RTL and testbench

- Synthesisable transmit path sitting directly downstream of the bus-side UART strobe interface.
- Each CPU write, signalled by a falling edge on TX_n with the byte on indata, is queued in a small FIFO.
- Each queued byte is then shifted out on a single serial line as 8N1 asynchronous frames.
- Replaces the simulation-only character print with real serial output; the same block feeds a physical pin or a serial bus-functional model.

---
 rtl/uart_tx_serialiser.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_serialiser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serialiser.sv
// Bus-strobed UART transmitter: captures bytes on TX_n falling edges into a FIFO and shifts them out as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_serialiser #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] indata,
  input  logic       TX_n,
  output logic       txd,
  output logic       tx_empty,
  output logic       tx_full,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic          sync_meta;
  logic          sync_out;
  logic          sync_prev;
  logic          fall;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          push_ok;
  logic          pop;
  logic [7:0]    head;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_next;
  logic          bit_end;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          txd_next;
  logic          tx_empty_next;
`ifdef UART_TX_PARITY_EN
  logic          parity;
  logic          parity_next;
`endif

  // TX_n is asynchronous; the third flop remembers the previous synchronised value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= TX_n;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
    end
  end

  assign fall = sync_prev & ~sync_out;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign tx_full = full;
  assign head    = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = fall & (~full | pop);

  always_comb begin
    count_next = count;
    unique case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= indata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      if (fall && full && !pop) begin
        overrun <= 1'b1;
      end
    end
  end

  assign bit_end = (baud_cnt == '0);

  // txd_next is the line level for the state being entered, so txd and state change on the same edge.
  always_comb begin
    state_next = state;
    baud_next  = bit_end ? '0 : baud_cnt - BW'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    txd_next   = 1'b1;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      S_IDLE: begin
        txd_next = 1'b1;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = head;
          baud_next  = RELOAD;
          state_next = S_START;
          txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^head;
`endif
        end
      end
      S_START: begin
        txd_next = 1'b0;
        if (bit_end) begin
          state_next = S_DATA;
          bit_next   = '0;
          baud_next  = RELOAD;
          txd_next   = shift[0];
        end
      end
      S_DATA: begin
        txd_next = shift[0];
        if (bit_end) begin
          baud_next = RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            txd_next   = parity;
`else
            state_next = S_STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            shift_next = {1'b0, shift[7:1]};
            bit_next   = bit_idx + 3'd1;
            txd_next   = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd_next = parity;
        if (bit_end) begin
          state_next = S_STOP;
          baud_next  = RELOAD;
          txd_next   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        txd_next = 1'b1;
        if (bit_end) begin
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = head;
            baud_next  = RELOAD;
            state_next = S_START;
            txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^head;
`endif
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  assign tx_empty_next = (count_next == '0) && (state_next == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      tx_empty <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      txd      <= txd_next;
      tx_empty <= tx_empty_next;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serialiser.sv
// Directed bench for uart_tx_serialiser: a serial receiver pops expected bytes from a scoreboard queue.
// Honours UART_TX_PARITY_EN for 8E1 framing.
module tb_uart_tx_serialiser;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CLKS = NB * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       TX_n = 1'b1;
  logic [7:0] indata = 8'h00;
  logic       txd;
  logic       tx_empty;
  logic       tx_full;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  int rx_start = 0;
  int last_start = 0;
  int prev_start = 0;
  logic [7:0] exp_q [$];

  logic [NB-1:0] rx_bits;
  logic          rx_held;
  logic          rx_abort;
  logic          rx_v;
  logic [7:0]    rx_exp;
  logic          last_parity;

  uart_tx_serialiser #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .indata   (indata),
    .TX_n     (TX_n),
    .txd      (txd),
    .tx_empty (tx_empty),
    .tx_full  (tx_full),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input int low_clks, input int high_clks,
                                input bit accepted);
    @(negedge clk);
    indata = data;
    TX_n   = 1'b0;
    if (accepted) exp_q.push_back(data);
    repeat (low_clks) @(negedge clk);
    TX_n = 1'b1;
    repeat (high_clks) @(negedge clk);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (tx_empty !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, tx_empty, 1);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, frames, target);
  endtask

  // Serial receiver: every clk of every bit slot is sampled so a mis-timed edge shows up as an unsteady bit.
  initial begin : receiver
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && txd === 1'b0) begin
        rx_start = cyc;
        rx_held  = 1'b1;
        rx_abort = 1'b0;
        for (int s = 0; s < NB; s++) begin
          for (int c = 0; c < CPB; c++) begin
            if (!(s == 0 && c == 0)) @(negedge clk);
            if (reset_n !== 1'b1) rx_abort = 1'b1;
            if (!rx_abort) begin
              rx_v = txd;
              if (c == 0) rx_bits[s] = rx_v;
              else if (rx_v !== rx_bits[s]) rx_held = 1'b0;
            end
          end
        end
        if (!rx_abort) begin
          prev_start = last_start;
          last_start = rx_start;
          check_output("rx_start_bit", rx_bits[0], 0);
          check_output("rx_stop_bit", rx_bits[NB-1], 1);
          check_output("rx_bit_steady", rx_held, 1);
          check_output("rx_frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            rx_exp = exp_q.pop_front();
            check_output("rx_data", rx_bits[8:1], rx_exp);
`ifdef UART_TX_PARITY_EN
            last_parity = rx_bits[9];
            check_output("rx_parity", rx_bits[9], ^rx_exp);
`endif
          end
          frames++;
        end
      end
    end
  end

  initial begin : stimulus
    int fall_cyc;
    int base;
    int low_count;

    // Reset held while the strobe toggles: nothing may be captured.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    TX_n = 1'b0;
    repeat (4) @(negedge clk);
    TX_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_txd", txd, 1);
    check_output("reset_tx_empty", tx_empty, 1);
    check_output("reset_tx_full", tx_full, 0);
    check_output("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("reset_no_push", tx_empty, 1);
    check_output("reset_idle_txd", txd, 1);

    // Single 0x55 write: push lands on the third clk edge after the fall.
    @(negedge clk);
    fall_cyc = cyc;
    indata = 8'h55;
    TX_n = 1'b0;
    exp_q.push_back(8'h55);
    repeat (2) @(negedge clk);
    check_output("push_not_early", tx_empty, 1);
    @(negedge clk);
    check_output("push_after_3clk", tx_empty, 0);
    @(negedge clk);
    TX_n = 1'b1;
    wait_empty("single_empty", 200);
    check_output("single_latency", last_start - fall_cyc, 4);
    check_output("single_length", cyc - last_start, FRAME_CLKS);
    check_output("single_frames", frames, 1);

    // Back-to-back writes: second start bit follows the first stop bit directly.
    base = frames;
    apply_stimulus(8'h41, 4, 3, 1'b1);
    apply_stimulus(8'h0D, 4, 3, 1'b1);
    wait_frames("b2b_frames", base + 2, 300);
    check_output("b2b_no_gap", last_start - prev_start, FRAME_CLKS);
    wait_empty("b2b_empty", 100);

    // Six rapid writes while the first frame is in flight: the sixth overflows.
    base = frames;
    for (int i = 1; i <= 5; i++) apply_stimulus(8'(i), 4, 2, 1'b1);
    check_output("fifo_full", tx_full, 1);
    check_output("no_overrun_yet", overrun, 0);
    apply_stimulus(8'h06, 4, 2, 1'b0);
    check_output("overrun_set", overrun, 1);
    wait_frames("burst_frames", base + 5, 600);
    wait_empty("burst_empty", 100);
    check_output("overrun_sticky", overrun, 1);
    check_output("full_cleared", tx_full, 0);

    // Strobe held low for 20 clk: exactly one frame.
    base = frames;
    apply_stimulus(8'hA3, 20, 3, 1'b1);
    wait_frames("held_low_frame", base + 1, 200);
    wait_empty("held_low_empty", 100);
    repeat (60) @(negedge clk);
    check_output("held_low_single", frames, base + 1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1 and the frame is eleven bits.
    base = frames;
    apply_stimulus(8'h07, 4, 3, 1'b1);
    wait_empty("parity_empty", 200);
    check_output("parity_length", cyc - last_start, FRAME_CLKS);
    check_output("parity_frames", frames, base + 1);
    check_output("parity_bit", last_parity, 1);
`endif

    // Reset during the third data bit of 0xFF with two bytes queued behind it.
    base = frames;
    apply_stimulus(8'hFF, 3, 2, 1'b1);
    apply_stimulus(8'h11, 3, 2, 1'b1);
    apply_stimulus(8'h22, 3, 2, 1'b1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("abort_txd", txd, 1);
    check_output("abort_tx_empty", tx_empty, 1);
    check_output("abort_tx_full", tx_full, 0);
    check_output("abort_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    low_count = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_count++;
    end
    check_output("abort_line_idle", low_count, 0);
    check_output("abort_no_frames", frames, base);
    check_output("abort_still_empty", tx_empty, 1);

    check_output("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
